// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: forwarding select encodings and the
// scoreboard slot record used by the forwarding unit.
package mips_pkg;

    localparam int unsigned REG_BITS = 5;
    localparam int unsigned CNT_BITS = 16;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;
    localparam logic [1:0] FWD_WBHOLD  = 2'b11;

    localparam logic [REG_BITS-1:0] REG_ZERO = REG_BITS'(0);

    // One in-flight instruction as seen by the scoreboard.
    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [REG_BITS-1:0] wr_reg;
        logic                is_load;
    } slot_t;

    // True when a slot will produce the value of register r (never for $0).
    function automatic logic slot_hits(slot_t s, logic [REG_BITS-1:0] r);
        return s.valid && s.wr_en && (r != REG_ZERO) && (s.wr_reg == r);
    endfunction

endpackage

// File: rtl/forwarding_unit_if.sv
// ID-stage <-> forwarding unit bus.
//   master: ID stage (drives instruction fields, flush; receives stall/selects)
//   slave : forwarding unit
interface forwarding_unit_if;
    import mips_pkg::*;

    logic                id_valid;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                id_uses_rs;
    logic                id_uses_rt;
    logic                id_wr_en;
    logic [REG_BITS-1:0] id_wr_reg;
    logic                id_is_load;
    logic                flush;
    logic                stall;
    logic [1:0]          fwd_a_sel;
    logic [1:0]          fwd_b_sel;
    logic [CNT_BITS-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_wr_en, id_wr_reg, id_is_load, flush,
        input  stall, fwd_a_sel, fwd_b_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_wr_en, id_wr_reg, id_is_load, flush,
        output stall, fwd_a_sel, fwd_b_sel, stall_count
    );

endinterface

// File: rtl/forwarding_unit_fwd_select.sv
// Combinational priority encoder: one source register against the
// EX/MEM/WB scoreboard slots. Nearest producer wins.
//   i_reg, i_uses        : source register index and whether it is read
//   i_ex, i_mem, i_wb    : scoreboard slots
//   o_sel_c              : operand mux select
//   o_fwd_load_c         : the chosen producer is a load
module fwd_select
    import mips_pkg::*;
(
    input  logic [REG_BITS-1:0] i_reg,
    input  logic                i_uses,
    input  slot_t               i_ex,
    input  slot_t               i_mem,
    input  slot_t               i_wb,
    output logic [1:0]          o_sel_c,
    output logic                o_fwd_load_c
);

    always_comb begin
        o_sel_c      = FWD_RF;
        o_fwd_load_c = 1'b0;
        if (i_uses && slot_hits(i_ex, i_reg)) begin
            o_sel_c      = FWD_EXMEM;
            o_fwd_load_c = i_ex.is_load;
        end else if (i_uses && slot_hits(i_mem, i_reg)) begin
            o_sel_c      = FWD_MEMWB;
            o_fwd_load_c = i_mem.is_load;
        end else if (i_uses && slot_hits(i_wb, i_reg)) begin
            o_sel_c      = FWD_WBHOLD;
            o_fwd_load_c = i_wb.is_load;
        end
    end

endmodule

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding and load-use stall controller.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ID instruction fields and flush in; stall (combinational),
//                registered fwd_a_sel/fwd_b_sel and saturating stall_count out
module forwarding_unit
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    forwarding_unit_if.slave  bus
);

    slot_t               r_ex;
    slot_t               r_mem;
    slot_t               r_wb;
    logic [1:0]          r_fwd_a_sel;
    logic [1:0]          r_fwd_b_sel;
    logic [CNT_BITS-1:0] r_stall_count;

    logic [1:0] w_sel_a_c;
    logic [1:0] w_sel_b_c;
    logic       w_load_a_c;
    logic       w_load_b_c;
    logic       w_load_use;
    logic       w_stall;
    logic       w_advance;
    slot_t      w_id_slot;

    fwd_select u_sel_a (
        .i_reg        (bus.id_rs),
        .i_uses       (bus.id_uses_rs),
        .i_ex         (r_ex),
        .i_mem        (r_mem),
        .i_wb         (r_wb),
        .o_sel_c      (w_sel_a_c),
        .o_fwd_load_c (w_load_a_c)
    );

    fwd_select u_sel_b (
        .i_reg        (bus.id_rt),
        .i_uses       (bus.id_uses_rt),
        .i_ex         (r_ex),
        .i_mem        (r_mem),
        .i_wb         (r_wb),
        .o_sel_c      (w_sel_b_c),
        .o_fwd_load_c (w_load_b_c)
    );

    // A load still in EX cannot forward yet; a load in MEM/WB never stalls.
    assign w_load_use = ((w_sel_a_c == FWD_EXMEM) && w_load_a_c) ||
                        ((w_sel_b_c == FWD_EXMEM) && w_load_b_c);

    // Flush dominates a hazard; reset masks the stall entirely.
    assign w_stall   = !reset && bus.id_valid && !bus.flush && w_load_use;
    assign w_advance = bus.id_valid && !w_stall && !bus.flush;

    assign w_id_slot = '{valid:   1'b1,
                         wr_en:   bus.id_wr_en,
                         wr_reg:  bus.id_wr_reg,
                         is_load: bus.id_is_load};

    // Scoreboard shift, select registers and stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_fwd_a_sel   <= FWD_RF;
            r_fwd_b_sel   <= FWD_RF;
            r_stall_count <= '0;
        end else begin
            r_wb          <= r_mem;
            r_mem         <= r_ex;
            r_ex          <= w_advance ? w_id_slot : '0;
            r_fwd_a_sel   <= w_advance ? w_sel_a_c : FWD_RF;
            r_fwd_b_sel   <= w_advance ? w_sel_b_c : FWD_RF;
            if (w_stall && (r_stall_count != {CNT_BITS{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_BITS'(1);
            end
        end
    end

    assign bus.stall       = w_stall;
    assign bus.fwd_a_sel   = r_fwd_a_sel;
    assign bus.fwd_b_sel   = r_fwd_b_sel;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit: directed hazard scenarios with
// literal expectations, then randomized traffic against a history model.
module tb_forwarding_unit;
    import mips_pkg::*;

    logic clk;
    logic reset;

    forwarding_unit_if bus ();

    forwarding_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: last three instructions issued into EX, index 0 = youngest.
    typedef struct {
        bit v;
        bit we;
        int r;
        bit ld;
    } ent_t;

    ent_t hist[3];
    int   exp_a, exp_b, exp_cnt;
    bit   last_stall;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit produces(int d, int r, bit u);
        return u && (r != 0) && hist[d].v && hist[d].we && (hist[d].r == r);
    endfunction

    // Select value equals the distance (1..3) to the nearest producer.
    function automatic int model_sel(int r, bit u);
        for (int d = 0; d < 3; d++)
            if (produces(d, r, u)) return d + 1;
        return 0;
    endfunction

    task automatic clear_hist();
        for (int d = 0; d < 3; d++) hist[d] = '{0, 0, 0, 0};
    endtask

    // One clock: drive at negedge, check stall, then check registered outputs.
    task automatic step(input bit v, input int rs, input int rt, input bit urs,
                        input bit urt, input bit we, input int wr, input bit ld,
                        input bit fl, input bit rst);
        bit exp_stall, adv;
        @(negedge clk);
        reset          = rst;
        bus.id_valid   = v;
        bus.id_rs      = REG_BITS'(rs);
        bus.id_rt      = REG_BITS'(rt);
        bus.id_uses_rs = urs;
        bus.id_uses_rt = urt;
        bus.id_wr_en   = we;
        bus.id_wr_reg  = REG_BITS'(wr);
        bus.id_is_load = ld;
        bus.flush      = fl;
        #1;
        exp_stall = !rst && v && !fl && hist[0].ld &&
                    (produces(0, rs, urs) || produces(0, rt, urt));
        last_stall = bus.stall;
        chk("stall", int'(bus.stall), int'(exp_stall));
        @(posedge clk);
        if (rst) begin
            clear_hist();
            exp_a   = 0;
            exp_b   = 0;
            exp_cnt = 0;
        end else begin
            adv   = v && !exp_stall && !fl;
            exp_a = adv ? model_sel(rs, urs) : 0;
            exp_b = adv ? model_sel(rt, urt) : 0;
            if (exp_stall && exp_cnt != 65535) exp_cnt++;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = adv ? '{1, we, wr, ld} : '{0, 0, 0, 0};
        end
        #1;
        chk("fwd_a_sel", int'(bus.fwd_a_sel), exp_a);
        chk("fwd_b_sel", int'(bus.fwd_b_sel), exp_b);
        chk("stall_count", int'(bus.stall_count), exp_cnt);
    endtask

    task automatic ins(input int rs, input int rt, input int wr, input bit we, input bit ld);
        step(1, rs, rt, 1, 1, we, wr, ld, 0, 0);
    endtask

    task automatic unrel();
        ins(0, 0, 20, 1, 0);
    endtask

    initial begin
        clear_hist();
        exp_a = 0; exp_b = 0; exp_cnt = 0;
        reset = 1'b1;
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0;
        bus.id_uses_rt = 0; bus.id_wr_en = 0; bus.id_wr_reg = '0;
        bus.id_is_load = 0; bus.flush = 0;

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_a", int'(bus.fwd_a_sel), 0);
        chk("rst_b", int'(bus.fwd_b_sel), 0);
        chk("rst_cnt", int'(bus.stall_count), 0);

        // Back-to-back ALU: add $3; sub $4,$3,$5
        ins(1, 2, 3, 1, 0);
        ins(3, 5, 4, 1, 0);
        chk("b2b_stall", int'(last_stall), 0);
        chk("b2b_a", int'(bus.fwd_a_sel), 1);
        chk("b2b_b", int'(bus.fwd_b_sel), 0);

        // Distance 2, 3, 4 on rt = $7
        ins(1, 2, 7, 1, 0); unrel(); ins(1, 7, 10, 1, 0);
        chk("dist2_b", int'(bus.fwd_b_sel), 2);
        ins(1, 2, 7, 1, 0); unrel(); unrel(); ins(1, 7, 10, 1, 0);
        chk("dist3_b", int'(bus.fwd_b_sel), 3);
        ins(1, 2, 7, 1, 0); unrel(); unrel(); unrel(); ins(1, 7, 10, 1, 0);
        chk("dist4_b", int'(bus.fwd_b_sel), 0);

        // Load-use: lw $8; add $9,$8,$8
        ins(1, 0, 8, 1, 1);
        ins(8, 8, 9, 1, 0);
        chk("lu_stall", int'(last_stall), 1);
        chk("lu_cnt", int'(bus.stall_count), 1);
        chk("lu_bubble_a", int'(bus.fwd_a_sel), 0);
        ins(8, 8, 9, 1, 0);
        chk("lu_retry_stall", int'(last_stall), 0);
        chk("lu_retry_a", int'(bus.fwd_a_sel), 2);
        chk("lu_retry_b", int'(bus.fwd_b_sel), 2);
        chk("lu_retry_cnt", int'(bus.stall_count), 1);

        // $0 never forwards; youngest of two writers wins
        ins(1, 1, 0, 1, 0); ins(0, 0, 11, 1, 0);
        chk("zero_a", int'(bus.fwd_a_sel), 0);
        chk("zero_b", int'(bus.fwd_b_sel), 0);
        ins(1, 1, 2, 1, 0); ins(1, 1, 2, 1, 0); ins(2, 0, 12, 1, 0);
        chk("prio_a", int'(bus.fwd_a_sel), 1);

        // Flush beats load-use
        ins(1, 0, 8, 1, 1);
        step(1, 8, 0, 1, 1, 1, 13, 0, 1, 0);
        chk("flush_stall", int'(last_stall), 0);
        chk("flush_a", int'(bus.fwd_a_sel), 0);
        ins(8, 0, 13, 1, 0);
        chk("flush_next_a", int'(bus.fwd_a_sel), 2);

        // Reset during a load-use stall
        ins(1, 0, 8, 1, 1);
        ins(8, 0, 14, 1, 0);
        chk("rs_stall", int'(last_stall), 1);
        chk("rs_cnt", int'(bus.stall_count), 2);
        step(1, 8, 0, 1, 1, 1, 14, 0, 0, 1);
        chk("rs_stall_in_reset", int'(last_stall), 0);
        chk("rs_cnt_clr", int'(bus.stall_count), 0);
        chk("rs_a_clr", int'(bus.fwd_a_sel), 0);
        ins(8, 0, 14, 1, 0);
        chk("rs_after_stall", int'(last_stall), 0);
        chk("rs_after_a", int'(bus.fwd_a_sel), 0);

        // Randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 85,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 75, int'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/forwarding_unit.md
# forwarding_unit

Pipeline hazard controller driving the 2-bit `sel` inputs of the two 4:1 EX-stage operand multiplexers (A and B) in the MIPS core. It tracks in-flight register writes in its own EX/MEM/WB scoreboard. It computes a registered forwarding select for each operand of the instruction entering EX, and raises a one-cycle stall on load-use hazards.

## Interface
- `REG_BITS`, 5: register-index width.
- `clk` input 1: sole clock, all state on rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `id_valid` input 1: ID holds a real instruction.
- `id_rs`, `id_rt` input REG_BITS: source registers in ID.
- `id_uses_rs`, `id_uses_rt` input 1: operand actually read.
- `id_wr_en` input 1: instruction writes a register.
- `id_wr_reg` input REG_BITS: destination register.
- `id_is_load` input 1: instruction is a load (result available at end of MEM).
- `flush` input 1: kill the instruction in ID (branch redirect).
- `stall` output 1: combinational; hold PC and IF/ID, insert bubble into EX.
- `fwd_a_sel`, `fwd_b_sel` output 2: registered; EX operand mux selects.
- `stall_count` output 16: saturating count of stall cycles.

## Operation
- Select encoding: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 WB hold register (the value retired one cycle earlier).
- Scoreboard holds three slots: `ex`, `mem`, `wb`. Each slot holds {valid, wr_en, wr_reg, is_load}.
- Every cycle, `wb`←`mem` and `mem`←`ex`. `ex`←ID entry when `id_valid & ~stall & ~flush`; otherwise `ex` takes a bubble (valid=0).
- Per operand, with `r`=id_rs or id_rt, the match is `uses & r≠0 & slot.valid & slot.wr_en & slot.wr_reg==r`:
  - match on current `ex` gives 01.
  - else match on current `mem` gives 10.
  - else match on current `wb` gives 11.
  - else 00.
- Priority is fixed as 01 > 10 > 11 > 00. Register 0 always yields 00.
- The select is registered on the same edge the instruction moves to EX. When the ID entry is not advanced (stall, flush, !id_valid), the next selects are 00.
- Load-use: `stall = id_valid & ~flush & (match on ex for rs or rt) & ex.is_load`. A stall lasts exactly one cycle, because the load then sits in `mem`. The retried instruction then receives 10.
- `stall_count` increments on each cycle with `stall=1` and saturates at 16'hFFFF.

## Timing
- Reset (synchronous) sets all slot valids to 0, `fwd_a_sel`/`fwd_b_sel` to 00, and `stall_count` to 0. `stall` is 0 while `reset` is high.
- Reset asserted mid-stall discards the scoreboard. The next instruction after reset sees 00 selects.
- Select latency: 1 clock. Values are presented for ID on cycle N and valid during cycle N+1, while the instruction is in EX.
- `stall` has 0-cycle latency, combinational from ID inputs and `ex` slot state.
- If `flush` and a hazard occur together, `flush` wins: `stall=0` and a bubble enters EX.
- Two slots writing the same register: the youngest (nearest) slot wins, per the priority above.
- A load in `mem` or `wb` never stalls. Its forwarding uses 10 or 11.

## Structure
- Shared package `mips_pkg` holds:
  - the constants `FWD_RF=2'b00`, `FWD_EXMEM=2'b01`, `FWD_MEMWB=2'b10`, `FWD_WBHOLD=2'b11`, `REG_ZERO`;
  - the slot record typedef {valid, wr_en, wr_reg, is_load}.
- Sub-module `fwd_select` is a combinational priority encoder, one register index against three slots. It is instantiated twice, for A and B.
- Top level holds the slot registers, stall logic, select registers and counter.

## Test plan
- **Back-to-back ALU:** `add $3,..` then `sub $4,$3,$5` → on the cycle `sub` is in EX, `fwd_a_sel=01`, `fwd_b_sel=00`, and `stall` stays 0.
- **Distance 2 and 3:** a writer of $7, then one unrelated instruction, then a reader of $7 in rt → `fwd_b_sel=10`. With two unrelated instructions in between → `fwd_b_sel=11`. With three in between → `00`.
- **Load-use:** `lw $8` then `add $9,$8,$8` → `stall=1` for exactly one cycle and `stall_count` goes 0→1. Then `fwd_a_sel=fwd_b_sel=10`.
- **$0 and priority:** writes to $0 followed by a read of $0 give 00. Two consecutive writers of $2 followed by a reader give 01, the youngest.
- **Flush vs. stall:** `lw $8` in EX, with a `$8` reader in ID and `flush=1` → `stall=0`, then EX bubble and selects 00.
- **Reset mid-operation:** assert `reset` one cycle during a load-use stall → next cycle all outputs are 0. An instruction reading the old load's register gets 00.
